// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver: frame-aligned digit loading,
// per-digit decimal point and blanking, leading-zero suppression, dead time and PWM.
module seven_seg_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 800
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*N_DIGITS-1:0] dig_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lzb,
    input  logic [3:0]            brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            ca,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int STEP = (CLK_DIV - DEAD_CYCLES) / 16;
    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] stg_dig;
    logic [4*N_DIGITS-1:0] disp_dig;
    logic [N_DIGITS-1:0]   stg_dp;
    logic [N_DIGITS-1:0]   disp_dp;

    logic                  boundary;
    logic [31:0]           cnt_ext;
    logic [31:0]           win_end;
    logic                  in_window;
    logic [N_DIGITS:0]     zero_from;
    logic [3:0]            cur_dig;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_zero;
    logic                  show;
    logic [N_DIGITS-1:0]   an_next;

    always_comb begin
        boundary  = (cnt == '0) && (idx == '0);
        cnt_ext   = 32'(cnt);
        win_end   = 32'(DEAD_CYCLES) + (32'(brightness) + 32'd1) * 32'(STEP);
        in_window = (cnt_ext >= 32'(DEAD_CYCLES)) && (cnt_ext < win_end);

        // zero_from[i]: display digits i..N_DIGITS-1 are all zero
        zero_from           = '0;
        zero_from[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_dig[4*i +: 4] == 4'd0);
        end

        cur_dig   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_zero  = 1'b0;
        an_next   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_dig    = disp_dig[4*i +: 4];
                cur_dp     = disp_dp[i];
                cur_blank  = blank_mask[i];
                cur_zero   = (i != 0) && zero_from[i];
                an_next[i] = 1'b0;
            end
        end

        show = in_window && !cur_blank && !(lzb && cur_zero);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt         <= '0;
            idx         <= '0;
            stg_dig     <= '0;
            stg_dp      <= '0;
            disp_dig    <= '0;
            disp_dp     <= '0;
            an          <= '1;
            ca          <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            // a load on the boundary cycle lands in staging after display copies it
            if (boundary) begin
                disp_dig <= stg_dig;
                disp_dp  <= stg_dp;
            end
            if (load) begin
                stg_dig <= dig_in;
                stg_dp  <= dp_in;
            end

            frame_start <= boundary;

            if (show) begin
                an <= an_next;
                ca <= hex7(cur_dig);
                dp <= ~cur_dp;
            end else begin
                an <= '1;
                ca <= 7'h7F;
                dp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: randomized and directed scenarios checked against
// a position-based model (absolute clock count -> slot, digit, window).
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int CD    = 36;
    localparam int DC    = 4;
    localparam int STEP  = (CD - DC) / 16;
    localparam int FRAME = CD * N;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] dig_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic        lzb;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp;
    logic        frame_start;

    int vectors    = 0;
    int miscompares = 0;

    // model state
    int          p;
    logic [15:0] m_stg, m_disp;
    logic [3:0]  m_stg_dp, m_disp_dp;
    logic [12:0] exp_all;
    logic [6:0]  glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seven_seg_scanner #(.N_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .clr(clr), .dig_in(dig_in), .dp_in(dp_in), .load(load),
        .blank_mask(blank_mask), .lzb(lzb), .brightness(brightness),
        .an(an), .ca(ca), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Predict the outputs produced by the next clock from the absolute position p,
    // then advance the clock and settle 1 time unit past the edge.
    task automatic tick();
        int         c, id, win_end;
        logic [3:0] e_an;
        logic [6:0] e_ca;
        logic       e_dp, e_fs;
        c       = p % CD;
        id      = (p / CD) % N;
        win_end = DC + (int'(brightness) + 1) * STEP;
        e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1;
        e_fs = (p % FRAME) == 0;
        if (c >= DC && c < win_end && !blank_mask[id] &&
            !(lzb && id > 0 && (m_disp >> (4 * id)) == 16'd0)) begin
            e_an[id] = 1'b0;
            e_ca     = glyph[m_disp[4*id +: 4]];
            e_dp     = ~m_disp_dp[id];
        end
        exp_all = {e_an, e_ca, e_dp, e_fs};
        if (e_fs) begin
            m_disp    = m_stg;
            m_disp_dp = m_stg_dp;
        end
        if (load) begin
            m_stg    = dig_in;
            m_stg_dp = dp_in;
        end
        p++;
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int pos);
        while (p % FRAME != pos) tick();
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b0;
        #1;
        vectors++;
        if ({an, ca, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_dark got %b want %b", tag, {an, ca, dp, frame_start},
                     {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        p = 0; m_stg = '0; m_disp = '0; m_stg_dp = '0; m_disp_dp = '0;
        #1;
        clr = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset");
        tick();
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_fs got %b want 1", frame_start);
        end
    endtask

    task automatic test_idle_scan();
        int fs_cnt = 0, an0_cnt = 0;
        while (p < 1 + 2 * FRAME) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL idle_scan pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            if (p - 1 < CD && an[0] === 1'b0) an0_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        vectors++;
        if (an0_cnt != CD - DC) begin
            miscompares++;
            $display("FAIL idle_an0_lit got %0d want %0d", an0_cnt, CD - DC);
        end
        vectors++;
        if (fs_cnt != 2) begin
            miscompares++;
            $display("FAIL idle_fs_count got %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_midframe_load();
        advance_to(70);
        dig_in = 16'h12AF; dp_in = 4'($urandom); load = 1'b1;
        tick();
        load = 1'b0;
        do begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL midload_old pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            if (an !== 4'hF) begin
                vectors++;
                if (ca !== 7'b1000000) begin
                    miscompares++;
                    $display("FAIL midload_tear got %b want 1000000", ca);
                end
            end
        end while (p % FRAME != 0);
        repeat (FRAME) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL midload_new pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            if (an === 4'b1110) begin
                vectors++;
                if (ca !== 7'b0001110) begin
                    miscompares++;
                    $display("FAIL midload_d0 got %b want 0001110", ca);
                end
            end
            if (an === 4'b0111) begin
                vectors++;
                if (ca !== 7'b1111001) begin
                    miscompares++;
                    $display("FAIL midload_d3 got %b want 1111001", ca);
                end
            end
        end
    endtask

    task automatic test_brightness();
        int levels [3];
        levels = '{0, 7, int'($urandom_range(1, 14))};
        foreach (levels[k]) begin
            int lit [N];
            brightness = 4'(levels[k]);
            advance_to(0);
            for (int d = 0; d < N; d++) lit[d] = 0;
            repeat (FRAME) begin
                tick();
                vectors++;
                if ({an, ca, dp, frame_start} !== exp_all) begin
                    miscompares++;
                    $display("FAIL bright%0d pos=%0d got %b want %b", levels[k], p - 1, {an, ca, dp, frame_start}, exp_all);
                end
                if ((p - 1) % CD < DC) begin
                    vectors++;
                    if (an !== 4'hF) begin
                        miscompares++;
                        $display("FAIL bright_dead got %b want 1111", an);
                    end
                end
                for (int d = 0; d < N; d++) if (an[d] === 1'b0) lit[d]++;
            end
            for (int d = 0; d < N; d++) begin
                vectors++;
                if (lit[d] != (levels[k] + 1) * STEP) begin
                    miscompares++;
                    $display("FAIL bright%0d_d%0d got %0d want %0d", levels[k], d, lit[d], (levels[k] + 1) * STEP);
                end
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_lzb();
        logic [15:0] pats [2];
        int          want [2][N];
        pats = '{16'h0030, 16'h0000};
        want = '{'{32, 32, 0, 0}, '{32, 0, 0, 0}};
        lzb = 1'b1; blank_mask = '0; brightness = 4'd15;
        for (int k = 0; k < 2; k++) begin
            int lit [N];
            dig_in = pats[k]; dp_in = '0; load = 1'b1;
            tick();
            load = 1'b0;
            advance_to(0);
            for (int d = 0; d < N; d++) lit[d] = 0;
            repeat (FRAME) begin
                tick();
                vectors++;
                if ({an, ca, dp, frame_start} !== exp_all) begin
                    miscompares++;
                    $display("FAIL lzb%0d pos=%0d got %b want %b", k, p - 1, {an, ca, dp, frame_start}, exp_all);
                end
                for (int d = 0; d < N; d++) if (an[d] === 1'b0) lit[d]++;
            end
            for (int d = 0; d < N; d++) begin
                vectors++;
                if (lit[d] != want[k][d]) begin
                    miscompares++;
                    $display("FAIL lzb%0d_d%0d got %0d want %0d", k, d, lit[d], want[k][d]);
                end
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_blank_dp();
        blank_mask = 4'b0100; lzb = 1'b0;
        dig_in = 16'($urandom) | 16'h1111; dp_in = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        advance_to(0);
        repeat (FRAME + 1) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL blank_dp pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            vectors++;
            if (an[2] !== 1'b1 || (dp === 1'b0) !== (an[1] === 1'b0)) begin
                miscompares++;
                $display("FAIL blank_dp_rule an=%b dp=%b want an[2]=1 and dp low only with an[1]", an, dp);
            end
        end
        blank_mask = '0;
    endtask

    task automatic test_random();
        repeat (6 * FRAME) begin
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 39) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 39) == 0) lzb = 1'($urandom);
            load = ($urandom_range(0, 49) == 0);
            if (load) begin
                dig_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                dp_in  = 4'($urandom);
            end
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL random pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
        end
        load = 1'b0; blank_mask = '0; lzb = 1'b0; brightness = 4'd15;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'($urandom) | 16'h8888;
        b = a ^ 16'h5A5A;
        dig_in = a; dp_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        advance_to(0);
        tick();
        advance_to(0);
        dig_in = b; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (FRAME - 1) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL b2b_old pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            if (an === 4'b1110) begin
                vectors++;
                if (ca !== glyph[a[3:0]]) begin
                    miscompares++;
                    $display("FAIL b2b_late_d0 got %b want %b", ca, glyph[a[3:0]]);
                end
            end
        end
        repeat (60) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL b2b_new pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
        end
        do_reset("midreset");
        repeat (FRAME + 1) begin
            tick();
            vectors++;
            if ({an, ca, dp, frame_start} !== exp_all) begin
                miscompares++;
                $display("FAIL post_reset pos=%0d got %b want %b", p - 1, {an, ca, dp, frame_start}, exp_all);
            end
            if (an !== 4'hF) begin
                vectors++;
                if (ca !== 7'b1000000) begin
                    miscompares++;
                    $display("FAIL post_reset_zero got %b want 1000000", ca);
                end
            end
        end
    endtask

    initial begin
        clr = 1'b1; load = 1'b0; dig_in = '0; dp_in = '0;
        blank_mask = '0; lzb = 1'b0; brightness = 4'd15;
        p = 0; m_stg = '0; m_disp = '0; m_stg_dp = '0; m_disp_dp = '0; exp_all = '0;
        #1;
        test_reset();
        test_idle_scan();
        test_midframe_load();
        test_brightness();
        test_lzb();
        test_blank_dp();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
